// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the core and muldiv_unit (register-file read ports in, write port out).
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic [4:0]       rd_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [4:0]       rd_out;
    logic             we;

    modport master (output start, op, src_a, src_b, rd_in,
                    input  busy, done, result, rd_out, we);
    modport slave  (input  start, op, src_a, src_b, rd_in,
                    output busy, done, result, rd_out, we);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative unsigned MUL/MULHU/DIVU/REMU unit with start/busy/done handshake driving the RF write port.
// Define MULDIV_DIV_EN to build the restoring divider; without it DIVU/REMU complete in one cycle with 0.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input logic          clk,
    input logic          rst,
    muldiv_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    typedef struct packed {
        logic       hi_sel;  // pick upper half of acc: MULHU high word / REMU remainder
        logic       short_op;
        logic [4:0] rd;
    } req_t;

    state_t             state, state_nxt;
    req_t               req_q;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   opnd;
    logic [2*WIDTH-1:0] acc, acc_nxt;
    logic [WIDTH-1:0]   result_q;
    logic [4:0]         rd_out_q;
    logic [WIDTH:0]     msum;
    logic               accept, last, running, short_op;
`ifdef MULDIV_DIV_EN
    logic [WIDTH:0]     rsh, rdif;
`endif

    assign accept  = bus.start && (state == S_IDLE || state == S_DONE);
    assign last    = (cnt == CW'(WIDTH - 1));
    assign running = (state == S_MUL) || (state == S_DIV);

    // Divides that need no iterations still spend one cycle in DIV with the
    // counter preloaded, so every op completes through the same last-iteration path.
`ifdef MULDIV_DIV_EN
    assign short_op = bus.op[1] && (bus.src_b == '0);
`else
    assign short_op = bus.op[1];
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (bus.start)            state_nxt = bus.op[1] ? S_DIV : S_MUL;
                else if (state == S_DONE) state_nxt = S_IDLE;
            end
            S_MUL, S_DIV: if (last) state_nxt = S_DONE;
            default:      state_nxt = S_IDLE;
        endcase
    end

    // acc = {hi, lo}: multiply keeps partial sum in hi and shifts the multiplier out of lo;
    // divide keeps the remainder in hi and shifts dividend bits out / quotient bits into lo.
    always_comb begin
        msum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd & {WIDTH{acc[0]}}};
        acc_nxt = {msum, acc[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
        rsh  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        rdif = rsh - {1'b0, opnd};
        if (state == S_DIV)
            acc_nxt = rdif[WIDTH] ? {rsh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                  : {rdif[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_q    <= '0;
            cnt      <= '0;
            opnd     <= '0;
            acc      <= '0;
            result_q <= '0;
            rd_out_q <= '0;
        end else if (accept) begin
            req_q <= '{hi_sel: bus.op[0], short_op: short_op, rd: bus.rd_in};
            cnt   <= short_op ? CW'(WIDTH - 1) : '0;
            if (!bus.op[1]) begin
                opnd <= bus.src_a;
                acc  <= {{WIDTH{1'b0}}, bus.src_b};
            end else if (short_op) begin
`ifdef MULDIV_DIV_EN
                opnd <= bus.op[0] ? bus.src_a : '1;
`else
                opnd <= '0;
`endif
            end else begin
                opnd <= bus.src_b;
                acc  <= {{WIDTH{1'b0}}, bus.src_a};
            end
        end else if (running) begin
            acc <= acc_nxt;
            cnt <= cnt + 1'b1;
            if (last) begin
                if (req_q.short_op)   result_q <= opnd;
                else if (req_q.hi_sel) result_q <= acc_nxt[2*WIDTH-1:WIDTH];
                else                   result_q <= acc_nxt[WIDTH-1:0];
                rd_out_q <= req_q.rd;
            end
        end
    end

    assign bus.busy   = (state != S_IDLE);
    assign bus.done   = (state == S_DONE);
    assign bus.result = result_q;
    assign bus.rd_out = rd_out_q;
    assign bus.we     = (state == S_DONE) && (rd_out_q != '0);
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed test-plan cases plus randomized ops against an arithmetic model.
module tb_muldiv_unit;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    muldiv_unit_if #(.WIDTH(32)) bus ();
    muldiv_unit #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = {32'd0, a} * {32'd0, b};
        case (op)
            2'd0: return p[31:0];
            2'd1: return p[63:32];
`ifdef MULDIV_DIV_EN
            2'd2: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            default: return (b == 32'd0) ? a : a % b;
`else
            default: return 32'd0;
`endif
        endcase
    endfunction

    function automatic int ref_lat(input logic [1:0] op, input logic [31:0] b);
        if (!op[1]) return 32;
`ifdef MULDIV_DIV_EN
        if (b != 32'd0) return 32;
`endif
        return 1;
    endfunction

    // Issues one request (accepted on the next edge), scrambles inputs afterwards, waits for done.
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                         output int cyc, output logic [31:0] res, output logic [4:0] rdo,
                         output logic weo, output logic busy1);
        bus.start = 1'b1; bus.op = op; bus.src_a = a; bus.src_b = b; bus.rd_in = rd;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.op = 2'($urandom); bus.src_a = $urandom; bus.src_b = $urandom;
        bus.rd_in = 5'($urandom);
        busy1 = bus.busy;
        cyc = -1;
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) begin cyc = c; break; end
        end
        res = bus.result; rdo = bus.rd_out; weo = bus.we;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.start = 1'b0; bus.op = 2'd0; bus.src_a = '0; bus.src_b = '0; bus.rd_in = '0;
        repeat (2) @(posedge clk); #1;
        n_cmp++;
        if ({bus.busy, bus.done, bus.we, bus.result, bus.rd_out} !== '0) begin
            n_err++;
            $display("FAIL reset_state got busy=%b done=%b we=%b result=%h rd=%0d, want all 0",
                     bus.busy, bus.done, bus.we, bus.result, bus.rd_out);
        end
        rst = 1'b1;
    endtask

    task automatic test_mul();
        int cyc; logic [31:0] res; logic [4:0] rdo; logic weo, b1;
        do_op(2'd0, 32'h1234_5678, 32'h10, 5'd5, cyc, res, rdo, weo, b1);
        n_cmp++;
        if (cyc !== 32 || res !== 32'h2345_6780 || rdo !== 5'd5 || weo !== 1'b1 || b1 !== 1'b1) begin
            n_err++;
            $display("FAIL mul_basic got cyc=%0d res=%h rd=%0d we=%b busy=%b, want 32 23456780 5 1 1",
                     cyc, res, rdo, weo, b1);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.we !== 1'b0) begin
            n_err++;
            $display("FAIL mul_pulse got done=%b busy=%b we=%b, want 0 0 0", bus.done, bus.busy, bus.we);
        end
    endtask

    task automatic test_mulhu();
        int cyc; logic [31:0] res; logic [4:0] rdo; logic weo, b1;
        do_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9, cyc, res, rdo, weo, b1);
        n_cmp++;
        if (res !== 32'hFFFF_FFFE || cyc !== 32) begin
            n_err++; $display("FAIL mulhu_max got res=%h cyc=%0d, want fffffffe 32", res, cyc);
        end
        @(posedge clk); #1;
        do_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9, cyc, res, rdo, weo, b1);
        n_cmp++;
        if (res !== 32'h0000_0001) begin
            n_err++; $display("FAIL mul_max got res=%h, want 00000001", res);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_div();
        int cyc; logic [31:0] res; logic [4:0] rdo; logic weo, b1;
        do_op(2'd2, 32'd100, 32'd7, 5'd3, cyc, res, rdo, weo, b1);
        n_cmp++;
        if (res !== ref_res(2'd2, 32'd100, 32'd7) || cyc !== ref_lat(2'd2, 32'd7)) begin
            n_err++; $display("FAIL divu_100_7 got res=%0d cyc=%0d, want %0d %0d",
                              res, cyc, ref_res(2'd2, 32'd100, 32'd7), ref_lat(2'd2, 32'd7));
        end
        @(posedge clk); #1;
        do_op(2'd3, 32'd100, 32'd7, 5'd3, cyc, res, rdo, weo, b1);
        n_cmp++;
        if (res !== ref_res(2'd3, 32'd100, 32'd7) || cyc !== ref_lat(2'd3, 32'd7)) begin
            n_err++; $display("FAIL remu_100_7 got res=%0d cyc=%0d, want %0d %0d",
                              res, cyc, ref_res(2'd3, 32'd100, 32'd7), ref_lat(2'd3, 32'd7));
        end
        @(posedge clk); #1;
        do_op(2'd3, 32'd5, 32'd9, 5'd3, cyc, res, rdo, weo, b1);
        n_cmp++;
        if (res !== ref_res(2'd3, 32'd5, 32'd9)) begin
            n_err++; $display("FAIL remu_small got res=%0d, want %0d", res, ref_res(2'd3, 32'd5, 32'd9));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_divzero();
        int cyc; logic [31:0] res; logic [4:0] rdo; logic weo, b1;
        for (int k = 2; k <= 3; k++) begin
            do_op(2'(k), 32'h1234, 32'd0, 5'd7, cyc, res, rdo, weo, b1);
            n_cmp++;
            if (res !== ref_res(2'(k), 32'h1234, 32'd0) || cyc !== 1 || weo !== 1'b1 || rdo !== 5'd7) begin
                n_err++; $display("FAIL divzero_op%0d got res=%h cyc=%0d we=%b rd=%0d, want %h 1 1 7",
                                  k, res, cyc, weo, rdo, ref_res(2'(k), 32'h1234, 32'd0));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_rd0();
        int cyc; logic [31:0] res; logic [4:0] rdo; logic weo, b1;
        do_op(2'd0, 32'd3, 32'd4, 5'd0, cyc, res, rdo, weo, b1);
        n_cmp++;
        if (cyc !== 32 || res !== 32'd12 || weo !== 1'b0 || rdo !== 5'd0) begin
            n_err++; $display("FAIL rd0_nowrite got cyc=%0d res=%0d we=%b, want 32 12 0", cyc, res, weo);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int cyc; logic [31:0] res; logic [4:0] rdo; logic weo, b1;
        do_op(2'd2, 32'd100, 32'd7, 5'd1, cyc, res, rdo, weo, b1);
        do_op(2'd3, 32'd100, 32'd7, 5'd2, cyc, res, rdo, weo, b1);
        n_cmp++;
        if (b1 !== 1'b1 || cyc !== ref_lat(2'd3, 32'd7) || res !== ref_res(2'd3, 32'd100, 32'd7) || rdo !== 5'd2) begin
            n_err++; $display("FAIL b2b_div got busy=%b cyc=%0d res=%0d rd=%0d, want 1 %0d %0d 2",
                              b1, cyc, res, rdo, ref_lat(2'd3, 32'd7), ref_res(2'd3, 32'd100, 32'd7));
        end
        do_op(2'd1, 32'hDEAD_BEEF, 32'h0BAD_F00D, 5'd4, cyc, res, rdo, weo, b1);
        n_cmp++;
        if (b1 !== 1'b1 || cyc !== 32 || res !== ref_res(2'd1, 32'hDEAD_BEEF, 32'h0BAD_F00D)) begin
            n_err++; $display("FAIL b2b_mulhu got busy=%b cyc=%0d res=%h, want 1 32 %h",
                              b1, cyc, res, ref_res(2'd1, 32'hDEAD_BEEF, 32'h0BAD_F00D));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_ignore_start();
        int cyc = -1;
        bus.start = 1'b1; bus.op = 2'd0; bus.src_a = 32'h0001_0003; bus.src_b = 32'h0000_0101; bus.rd_in = 5'd11;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            if (c == 5 || c == 20) begin
                bus.start = 1'b1; bus.op = 2'($urandom); bus.src_a = $urandom; bus.src_b = $urandom;
                bus.rd_in = 5'd22;
            end else bus.start = 1'b0;
            @(posedge clk); #1;
            if (bus.done === 1'b1) begin cyc = c; break; end
        end
        bus.start = 1'b0;
        n_cmp++;
        if (cyc !== 32 || bus.result !== ref_res(2'd0, 32'h0001_0003, 32'h0000_0101) || bus.rd_out !== 5'd11) begin
            n_err++; $display("FAIL ignore_start got cyc=%0d res=%h rd=%0d, want 32 %h 11",
                              cyc, bus.result, bus.rd_out, ref_res(2'd0, 32'h0001_0003, 32'h0000_0101));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_abort();
        logic seen = 1'b0;
`ifdef MULDIV_DIV_EN
        bus.op = 2'd2;
`else
        bus.op = 2'd0;
`endif
        bus.start = 1'b1; bus.src_a = 32'd1000; bus.src_b = 32'd7; bus.rd_in = 5'd6;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if ({bus.busy, bus.done, bus.we, bus.result, bus.rd_out} !== '0) begin
            n_err++; $display("FAIL reset_abort got busy=%b done=%b we=%b result=%h rd=%0d, want all 0",
                              bus.busy, bus.done, bus.we, bus.result, bus.rd_out);
        end
        @(negedge clk); rst = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (bus.done !== 1'b0 || bus.we !== 1'b0) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_err++; $display("FAIL reset_no_done got done_seen=%b, want 0", seen);
        end
    endtask

    task automatic test_random();
        int cyc; logic [31:0] res, a, b; logic [4:0] rdo, rd; logic weo, b1; logic [1:0] op;
        for (int i = 0; i < 30; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 300));
                default: b = $urandom;
            endcase
            rd = 5'($urandom_range(0, 31));
            do_op(op, a, b, rd, cyc, res, rdo, weo, b1);
            n_cmp++;
            if (res !== ref_res(op, a, b) || cyc !== ref_lat(op, b) || rdo !== rd || weo !== (rd != 5'd0)) begin
                n_err++; $display("FAIL rand_%0d op=%0d a=%h b=%h got res=%h cyc=%0d rd=%0d we=%b, want %h %0d %0d %b",
                                  i, op, a, b, res, cyc, rdo, weo, ref_res(op, a, b), ref_lat(op, b), rd, rd != 5'd0);
            end
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk); #1;
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_mul();
        test_mulhu();
        test_div();
        test_divzero();
        test_rd0();
        test_back_to_back();
        test_ignore_start();
        test_reset_abort();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit for the RISC-V core, sitting directly downstream of the register file. It consumes the two read ports (RD1/RD2) as operands and produces a result, destination index and write strobe that drive the register file write port (WD3/A3/WE3). It uses a start/busy/done handshake so the core can stall during multi-cycle M-extension operations.

## Interface
- WIDTH, 32, operand and result width; iteration count equals WIDTH.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  request pulse; sampled on the rising edge.
- op  input  2  operation select: 00 MUL (low word), 01 MULHU (high word, unsigned), 10 DIVU, 11 REMU.
- src_a  input  WIDTH  operand A (multiplicand or dividend), from RD1.
- src_b  input  WIDTH  operand B (multiplier or divisor), from RD2.
- rd_in  input  5  destination register index.
- busy  output  1  high while an operation is in progress, including the DONE cycle.
- done  output  1  one-cycle completion pulse.
- result  output  WIDTH  registered result; valid while done=1.
- rd_out  output  5  destination index captured at start.
- we  output  1  register-file write enable; equals done, and is 0 when rd_out=0.

## Operation
- States:
  - IDLE: busy=0.
  - MUL: shift-add multiply with a 2*WIDTH accumulator.
  - DIV: restoring divide with a WIDTH-bit remainder and WIDTH-bit quotient.
  - DONE.
- Transitions:
  - IDLE, start=1, op[1]=0 → MUL.
  - IDLE, start=1, op[1]=1, src_b≠0 → DIV.
  - IDLE, start=1, op[1]=1, src_b=0 → DONE.
  - MUL/DIV → DONE when iteration counter reaches WIDTH-1.
  - DONE, start=0 → IDLE.
  - DONE, start=1 → accepted exactly as from IDLE (back-to-back).
- Operand capture: the accepting edge latches op, src_a, src_b and rd_in. Later input changes have no effect.
- start while in MUL or DIV is ignored; it is not queued.
- Arithmetic: all operands are unsigned.
  - MUL returns product[WIDTH-1:0].
  - MULHU returns product[2*WIDTH-1:WIDTH].
  - DIVU returns the quotient.
  - REMU returns the remainder.
- Divide by zero (RISC-V semantics): DIVU returns all ones and REMU returns src_a. No iterations are performed.
- A dividend smaller than the divisor needs no special case: quotient 0, remainder = dividend.
- Reset: asynchronous assertion forces state IDLE, counter 0 and busy=done=we=0, with result=0 and rd_out=0. This aborts any operation in flight without a write. The first accepting edge is the first rising edge after rst deasserts.

## Timing
- Take the accepting edge as E.
  - MUL/DIV: iterations occur on edges E+1 through E+WIDTH. done=1 for the cycle after edge E+WIDTH, i.e. 32 cycles for WIDTH=32.
  - Divide by zero: done=1 for the cycle after edge E+1.
- busy rises after E and falls after the DONE cycle, unless a back-to-back start is accepted.
- result, rd_out and we are registered and change only together with done.
- No combinational path exists from any input to any output.

## Configuration
- MULDIV_DIV_EN defined: the DIV state and divider datapath are compiled in, with behaviour as above.
- MULDIV_DIV_EN undefined:
  - No divider logic is generated.
  - op=10/11 go IDLE → DONE with result=0 and done one cycle after acceptance.
  - we is still asserted, so rd is written with 0.
  - MUL and MULHU are unchanged.

## Test plan
- MUL with src_a=0x12345678, src_b=0x10, rd_in=5 → result=0x23456780, rd_out=5, we=1 exactly 32 cycles after the start edge, with a one-cycle done pulse.
- MULHU with 0xFFFFFFFF × 0xFFFFFFFF → result=0xFFFFFFFE. A following MUL with the same operands → 0x00000001.
- DIVU 100/7 → 14. REMU 100/7 → 2. Back-to-back start during DONE is accepted with no idle cycle.
- DIVU x/0 with src_a=0x1234 → 0xFFFFFFFF. REMU 0x1234/0 → 0x1234. Each has done one cycle after start. Without MULDIV_DIV_EN, op=10 gives result=0 one cycle after start.
- rd_in=0 with MUL 3×4 → done=1, result=12, we=0.
- Start pulses at cycles 5 and 20 of a MUL in flight are ignored and the original result is produced. Asserting rst at cycle 10 of a DIVU clears busy immediately, and no done or we follows.
